// File: rtl/slowdown_queue_pkg.sv
// Shared constants and helpers for the slowdown queue.
package slowdown_queue_pkg;

   // Default fetch-group geometry; these track the decoder's global defines.
   localparam int NUM_FETCH_DEF    = 2;
   localparam int BUFFER_WIDTH_DEF = 155;
   localparam int DEPTH_DEF        = 2;

   // Index width that never collapses to zero bits, so a depth of 1 still
   // gets a usable (always-zero) pointer.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slowdown_queue_lowest_set_index.sv
// Fixed-priority select of the lowest set bit of a mask, returned both as a
// one-hot vector and as its binary index. An all-zero mask yields index 0
// and an all-zero one-hot.
module slowdown_queue_lowest_set_index #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0]         mask,
   output logic [$clog2(WIDTH)-1:0] index,
   output logic [WIDTH-1:0]         onehot
);

   localparam int IDX_W = $clog2(WIDTH);

   // A bit wins only when every lower bit is clear.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pick
      if (gi == 0) begin : g_first
         assign onehot[gi] = mask[gi];
      end else begin : g_rest
         assign onehot[gi] = mask[gi] & ~(|mask[gi-1:0]);
      end
   end

   // Binary encode of the one-hot winner.
   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) index = index | i[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/slowdown_queue.sv
// Queue of decoded fetch groups that serialises each group into one control
// word per granted output handshake, lowest valid slot first.
module slowdown_queue
   import slowdown_queue_pkg::*;
#(
   parameter int NUM_FETCH    = NUM_FETCH_DEF,
   parameter int BUFFER_WIDTH = BUFFER_WIDTH_DEF,
   parameter int DEPTH        = DEPTH_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [NUM_FETCH-1:0]              in_mask_i,
   input  logic [BUFFER_WIDTH*NUM_FETCH-1:0] in_control_signals_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   input  logic                              out_grant_i,
   output logic [BUFFER_WIDTH-1:0]           out_control_signals_o,
   output logic [$clog2(NUM_FETCH)-1:0]      out_slot_o,
   output logic                              out_last_o,
   output logic [$clog2(DEPTH):0]            count_o
);

   localparam int SLOT_W = $clog2(NUM_FETCH);
   localparam int PTR_W  = idx_width(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   // Masks are control state and are reset; payloads are plain storage.
   logic [NUM_FETCH-1:0]              mask_reg    [DEPTH];
   logic [BUFFER_WIDTH*NUM_FETCH-1:0] payload_mem [DEPTH];

   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;

   logic [NUM_FETCH-1:0]              head_mask;
   logic [BUFFER_WIDTH*NUM_FETCH-1:0] head_payload;
   logic [BUFFER_WIDTH-1:0]           head_words [NUM_FETCH];
   logic [SLOT_W-1:0]                 head_idx;
   logic [NUM_FETCH-1:0]              head_onehot;
   logic                              head_single;
   logic                              retire;
   logic                              pop;
   logic                              accept;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (DEPTH == 1) return '0;
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_mask    = mask_reg[rd_ptr_reg];
   assign head_payload = payload_mem[rd_ptr_reg];

   slowdown_queue_lowest_set_index #(
      .WIDTH (NUM_FETCH)
   ) u_lsi (
      .mask   (head_mask),
      .index  (head_idx),
      .onehot (head_onehot)
   );

   // Slice the head payload into per-slot words.
   for (genvar gi = 0; gi < NUM_FETCH; gi++) begin : g_words
      assign head_words[gi] = head_payload[gi*BUFFER_WIDTH +: BUFFER_WIDTH];
   end

   // Exactly one bit left means this is the group's final word.
   assign head_single = (head_mask != '0) && ((head_mask & (head_mask - 1'b1)) == '0);

   assign out_valid_o           = (count_reg != '0);
   assign out_control_signals_o = head_words[head_idx];
   assign out_slot_o            = head_idx;
   assign out_last_o            = out_valid_o & head_single;
   assign count_o               = count_reg;

   assign retire     = out_valid_o & out_ready_i & out_grant_i;
   assign pop        = retire & out_last_o;
   // A popping head frees its entry this edge, so a full queue can still take
   // a group and back-to-back groups flow without a bubble.
   assign in_ready_o = (count_reg < CNT_W'(DEPTH)) | pop;
   // Empty-mask groups are consumed by the handshake but never stored.
   assign accept     = in_valid_i & in_ready_o & (|in_mask_i);

   // Next pointer and occupancy values for normal operation.
   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (pop)    rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (accept) wr_ptr_next = ptr_inc(wr_ptr_reg);
      case ({accept, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Control state: reset and flush both empty the queue; otherwise retire
   // clears the issued slot and accept loads the tail. When a full queue pops
   // and accepts on the same entry, the accept write is last and wins.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         for (int i = 0; i < DEPTH; i++) mask_reg[i] <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (retire) mask_reg[rd_ptr_reg] <= head_mask & ~head_onehot;
         if (accept) mask_reg[wr_ptr_reg] <= in_mask_i;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Payload storage, written only for groups that are actually queued.
   always_ff @(posedge clk) begin
      if (accept && !flush_i && !rst) payload_mem[wr_ptr_reg] <= in_control_signals_i;
   end

endmodule

// File: tb/tb_slowdown_queue.sv
// Directed bench for slowdown_queue: a 2-slot instance covers ordering,
// backpressure, grant gating, flush and reset; a 4-slot instance covers
// sparse masks.
module tb_slowdown_queue;

   localparam int BW  = 155;
   localparam int BW4 = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_mask;
   logic [2*BW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic          out_grant;
   logic [BW-1:0] out_ctrl;
   logic [0:0]    out_slot;
   logic          out_last;
   logic [1:0]    count;

   logic            d4_flush;
   logic            d4_in_valid;
   logic            d4_in_ready;
   logic [3:0]      d4_in_mask;
   logic [4*BW4-1:0] d4_in_ctrl;
   logic            d4_out_valid;
   logic            d4_out_ready;
   logic            d4_out_grant;
   logic [BW4-1:0]  d4_out_ctrl;
   logic [1:0]      d4_out_slot;
   logic            d4_out_last;
   logic [1:0]      d4_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   slowdown_queue #(.NUM_FETCH(2), .BUFFER_WIDTH(BW), .DEPTH(2)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .flush_i               (flush),
      .in_valid_i            (in_valid),
      .in_ready_o            (in_ready),
      .in_mask_i             (in_mask),
      .in_control_signals_i  (in_ctrl),
      .out_valid_o           (out_valid),
      .out_ready_i           (out_ready),
      .out_grant_i           (out_grant),
      .out_control_signals_o (out_ctrl),
      .out_slot_o            (out_slot),
      .out_last_o            (out_last),
      .count_o               (count)
   );

   slowdown_queue #(.NUM_FETCH(4), .BUFFER_WIDTH(BW4), .DEPTH(2)) dut4 (
      .clk                   (clk),
      .rst                   (rst),
      .flush_i               (d4_flush),
      .in_valid_i            (d4_in_valid),
      .in_ready_o            (d4_in_ready),
      .in_mask_i             (d4_in_mask),
      .in_control_signals_i  (d4_in_ctrl),
      .out_valid_o           (d4_out_valid),
      .out_ready_i           (d4_out_ready),
      .out_grant_i           (d4_out_grant),
      .out_control_signals_o (d4_out_ctrl),
      .out_slot_o            (d4_out_slot),
      .out_last_o            (d4_out_last),
      .count_o               (d4_count)
   );

   // Distinct full-width word built from a 31-bit seed.
   function automatic logic [BW-1:0] word(input int k);
      return {5{k[30:0]}};
   endfunction

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1-2 time units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mask = '0; in_ctrl = '0;
      out_ready = 1'b0; out_grant = 1'b0;
      d4_flush = 1'b0; d4_in_valid = 1'b0; d4_in_mask = '0; d4_in_ctrl = '0;
      d4_out_ready = 1'b1; d4_out_grant = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset_count", count, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_last", out_last, 0);
      chk("reset_slot", out_slot, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset4_valid", d4_out_valid, 0);

      // 1: full group A,B drained at full rate.
      out_ready = 1'b1; out_grant = 1'b1;
      in_valid = 1'b1; in_mask = 2'b11; in_ctrl = {word(32'h0B0B0B0B), word(32'h0A0A0A0A)};
      #1 chk("t1_in_ready", in_ready, 1);
      tick(); in_valid = 1'b0; #1;
      chk("t1_a_valid", out_valid, 1);
      chk("t1_a_data", out_ctrl, word(32'h0A0A0A0A));
      chk("t1_a_slot", out_slot, 0);
      chk("t1_a_last", out_last, 0);
      chk("t1_a_count", count, 1);
      tick(); #1;
      chk("t1_b_data", out_ctrl, word(32'h0B0B0B0B));
      chk("t1_b_slot", out_slot, 1);
      chk("t1_b_last", out_last, 1);
      chk("t1_b_count", count, 1);
      tick(); #1;
      chk("t1_end_count", count, 0);
      chk("t1_end_valid", out_valid, 0);

      // 2a: only slot 1 valid.
      in_valid = 1'b1; in_mask = 2'b10; in_ctrl = {word(32'h0C0C0C0C), word(32'h7FFF0000)};
      tick(); in_valid = 1'b0; #1;
      chk("t2a_slot", out_slot, 1);
      chk("t2a_data", out_ctrl, word(32'h0C0C0C0C));
      chk("t2a_last", out_last, 1);
      tick(); #1;
      chk("t2a_end_valid", out_valid, 0);

      // 2b: four-slot group with mask 1010 emits slots 1 then 3.
      d4_in_valid = 1'b1; d4_in_mask = 4'b1010;
      d4_in_ctrl = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      tick(); d4_in_valid = 1'b0; #1;
      chk("t2b_first_slot", d4_out_slot, 1);
      chk("t2b_first_data", d4_out_ctrl, 16'h2222);
      chk("t2b_first_last", d4_out_last, 0);
      tick(); #1;
      chk("t2b_second_slot", d4_out_slot, 3);
      chk("t2b_second_data", d4_out_ctrl, 16'h4444);
      chk("t2b_second_last", d4_out_last, 1);
      tick(); #1;
      chk("t2b_end_valid", d4_out_valid, 0);

      // 3: backpressure fills the queue, third group waits for a pop.
      out_ready = 1'b0; out_grant = 1'b0;
      in_valid = 1'b1; in_mask = 2'b11; in_ctrl = {word(32'h00000011), word(32'h00000010)};
      tick();
      in_ctrl = {word(32'h00000021), word(32'h00000020)};
      #1 chk("t3_g1_in_ready", in_ready, 1);
      tick();
      in_ctrl = {word(32'h00000031), word(32'h00000030)};
      #1;
      chk("t3_full_count", count, 2);
      chk("t3_full_in_ready", in_ready, 0);
      tick(); #1;
      chk("t3_held_count", count, 2);
      chk("t3_held_data", out_ctrl, word(32'h00000010));
      out_ready = 1'b1; out_grant = 1'b1;
      #1 chk("t3_notlast_in_ready", in_ready, 0);
      tick(); #1;
      chk("t3_g0b_data", out_ctrl, word(32'h00000011));
      chk("t3_pop_in_ready", in_ready, 1);
      tick(); in_valid = 1'b0; #1;
      chk("t3_swap_count", count, 2);
      chk("t3_g1a_data", out_ctrl, word(32'h00000020));
      tick(); #1;
      chk("t3_g1b_data", out_ctrl, word(32'h00000021));
      tick(); #1;
      chk("t3_g2a_data", out_ctrl, word(32'h00000030));
      chk("t3_g2a_count", count, 1);
      tick(); #1;
      chk("t3_g2b_data", out_ctrl, word(32'h00000031));
      chk("t3_g2b_last", out_last, 1);
      tick(); #1;
      chk("t3_end_count", count, 0);

      // 4: grant gating holds the head word.
      in_valid = 1'b1; in_mask = 2'b11; in_ctrl = {word(32'h00000071), word(32'h00000070)};
      tick(); in_valid = 1'b0; out_grant = 1'b0; #1;
      chk("t4_a_data", out_ctrl, word(32'h00000070));
      tick(); #1;
      chk("t4_hold_data", out_ctrl, word(32'h00000070));
      chk("t4_hold_slot", out_slot, 0);
      out_grant = 1'b1;
      tick(); #1;
      chk("t4_b_data", out_ctrl, word(32'h00000071));
      chk("t4_b_slot", out_slot, 1);
      tick(); #1;
      chk("t4_end_valid", out_valid, 0);

      // 5a: flush with an incoming group drops everything.
      out_ready = 1'b0; out_grant = 1'b0;
      in_valid = 1'b1; in_mask = 2'b11; in_ctrl = {word(32'h00000081), word(32'h00000080)};
      tick(); tick();
      flush = 1'b1; out_ready = 1'b1; out_grant = 1'b1;
      in_ctrl = {word(32'h00000091), word(32'h00000090)};
      #1 chk("t5_pre_count", count, 2);
      tick(); flush = 1'b0; in_valid = 1'b0; #1;
      chk("t5_flush_count", count, 0);
      chk("t5_flush_valid", out_valid, 0);
      tick(); #1;
      chk("t5_dropped_valid", out_valid, 0);

      // 5b: reset mid-group behaves the same.
      in_valid = 1'b1; in_mask = 2'b11; in_ctrl = {word(32'h000000A1), word(32'h000000A0)};
      tick(); in_valid = 1'b0; tick();
      #1 chk("t5_mid_data", out_ctrl, word(32'h000000A1));
      rst = 1'b1; in_valid = 1'b1; in_ctrl = {word(32'h000000B1), word(32'h000000B0)};
      tick(); rst = 1'b0; in_valid = 1'b0; #1;
      chk("t5_rst_count", count, 0);
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_last", out_last, 0);
      chk("t5_rst_slot", out_slot, 0);
      tick(); #1;
      chk("t5_rst_dropped", out_valid, 0);

      // 6: empty mask is consumed without queuing.
      in_valid = 1'b1; in_mask = 2'b00; in_ctrl = {word(32'h000000C1), word(32'h000000C0)};
      #1 chk("t6_in_ready", in_ready, 1);
      tick(); in_valid = 1'b0; #1;
      chk("t6_count", count, 0);
      chk("t6_valid", out_valid, 0);

      // Simultaneous pop and accept at count 1.
      in_valid = 1'b1; in_mask = 2'b10; in_ctrl = {word(32'h000000D1), word(32'h000000D0)};
      tick();
      in_mask = 2'b01; in_ctrl = {word(32'h000000E1), word(32'h000000E0)};
      #1 chk("t7_last_in_ready", in_ready, 1);
      tick(); in_valid = 1'b0; #1;
      chk("t7_count", count, 1);
      chk("t7_data", out_ctrl, word(32'h000000E0));
      chk("t7_last", out_last, 1);
      tick(); #1;
      chk("t7_end_count", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
